// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: owns the program counter, issues word-aligned requests to a
// one-cycle synchronous instruction memory, and hands fetched instructions to
// decode through a valid/ready output register backed by a one-entry skid
// buffer. A taken branch redirects the PC and flushes all wrong-path work.
`timescale 1ns/1ps
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_offset
);

  typedef enum logic [1:0] {BOOT, FETCH, FULL} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        inflight;
  logic        kill;
  logic        out_valid;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        redirect;
  logic        consume;
  logic        capture;
  logic        issue;
  logic        has_slot;
  logic [2:0]  occupied;
  logic [2:0]  capacity;
  logic [31:0] target;

  assign redirect  = br_valid & br_taken;
  assign consume   = out_valid & if_ready;
  assign capture   = inflight & ~kill;
  assign target    = (br_pc + 32'd4 + br_offset) & ~32'h3;
  assign if_valid  = out_valid;
  assign imem_addr = pc;
  assign imem_req  = issue;

  // Two buffer places exist (output register + skid); anything held or in
  // flight occupies one, and an entry leaving this cycle frees one.
  assign occupied = {2'b00, out_valid} + {2'b00, skid_valid} + {2'b00, inflight};
  assign capacity = 3'd2 + {2'b00, consume};
  assign has_slot = capacity > occupied;

  // Next-state and issue decision; BOOT suppresses the very first request.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      BOOT: begin
        state_next = FETCH;
      end
      FETCH, FULL: begin
        issue      = has_slot & ~redirect;
        state_next = has_slot ? FETCH : FULL;
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_next;
  end

  // Program counter, in-flight tag and kill flag; a redirect overrides issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      inflight <= issue;
      kill     <= redirect & inflight;
      if (issue) req_pc <= pc;
      if (redirect)   pc <= target;
      else if (issue) pc <= pc + 32'd4;
    end
  end

  // Output register and skid buffer: the skid entry is older than any
  // same-cycle response, so it always drains first to keep program order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else if (redirect) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || consume) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        if_instr   <= skid_instr;
        if_pc      <= skid_pc;
        skid_valid <= capture;
        if (capture) begin
          skid_instr <= imem_rdata;
          skid_pc    <= req_pc;
        end
      end else if (capture) begin
        out_valid <= 1'b1;
        if_instr  <= imem_rdata;
        if_pc     <= req_pc;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (capture) begin
      skid_valid <= 1'b1;
      skid_instr <= imem_rdata;
      skid_pc    <= req_pc;
    end
  end

endmodule
